// File: rtl/capture_seq.sv
// Capture sequencer: pre-trigger circular recording, masked level/edge trigger,
// post-trigger countdown and a one-cycle rst_trig acknowledge; single-shot or auto-rearm.
module capture_seq #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int NCH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic [NCH-1:0]    trig,
  input  logic [NCH-1:0]    trig_mask,
  input  logic              trig_edge,
  input  logic              mode,
  input  logic [ADDR_W-1:0] post_len,
  output logic              wren,
  output logic [ADDR_W-1:0] waddr,
  output logic              rst_trig,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [NCH-1:0]    trig_ch
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [NCH-1:0]    trig_q;
  logic [NCH-1:0]    cond;
  logic              hit;
  logic [ADDR_W-1:0] post_clamp;

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    if (a == LAST) return '0;
    else           return a + ADDR_W'(1);
  endfunction

  // Longer post windows would overwrite the trigger sample itself.
  function automatic logic [ADDR_W-1:0] clamp_post(input logic [ADDR_W-1:0] len);
    if (len > LAST) return LAST;
    else            return len;
  endfunction

  assign cond       = trig_edge ? (trig & ~trig_q) : trig;
  assign hit        = |(cond & trig_mask);
  assign post_clamp = clamp_post(post_len);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arm) state_nxt = ARMED;
      ARMED:   if (hit) state_nxt = (post_clamp == '0) ? ACK : POST;
      POST:    if (cnt <= ADDR_W'(1)) state_nxt = ACK;
      ACK:     state_nxt = mode ? ARMED : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wren     = 1'b0;
    rst_trig = 1'b0;
    busy     = 1'b0;
    case (state)
      ARMED:   begin wren = 1'b1; busy = 1'b1; end
      POST:    begin wren = 1'b1; busy = 1'b1; end
      ACK:     begin rst_trig = 1'b1; busy = 1'b1; end
      default: ;
    endcase
  end

  // Edge history runs in every state so a level held through ACK/IDLE never looks like a new edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_q    <= '0;
      waddr     <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      trig_addr <= '0;
      trig_ch   <= '0;
    end else begin
      trig_q <= trig;
      case (state)
        IDLE: begin
          if (arm) begin
            waddr <= '0;
            done  <= 1'b0;
          end
        end
        ARMED: begin
          waddr <= addr_inc(waddr);
          if (hit) begin
            trig_addr <= waddr;
            trig_ch   <= cond & trig_mask;
            cnt       <= post_clamp;
          end
        end
        POST: begin
          waddr <= addr_inc(waddr);
          cnt   <= cnt - ADDR_W'(1);
        end
        ACK:     done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_seq.sv
// Directed bench for capture_seq: one DEPTH=8 and one DEPTH=6 instance share stimulus;
// each scenario checks the instance whose geometry it exercises.
module tb_capture_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       arm;
  logic [3:0] trig;
  logic [3:0] trig_mask;
  logic       trig_edge;
  logic       mode;
  logic [2:0] post_len;

  logic       a_wren, a_rst_trig, a_busy, a_done;
  logic [2:0] a_waddr, a_trig_addr;
  logic [3:0] a_trig_ch;
  logic       b_wren, b_rst_trig, b_busy, b_done;
  logic [2:0] b_waddr, b_trig_addr;
  logic [3:0] b_trig_ch;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  capture_seq #(.ADDR_W(3), .DEPTH(8), .NCH(4)) dut_a (
    .clk(clk), .rst(rst), .arm(arm), .trig(trig), .trig_mask(trig_mask),
    .trig_edge(trig_edge), .mode(mode), .post_len(post_len),
    .wren(a_wren), .waddr(a_waddr), .rst_trig(a_rst_trig), .busy(a_busy),
    .done(a_done), .trig_addr(a_trig_addr), .trig_ch(a_trig_ch)
  );

  capture_seq #(.ADDR_W(3), .DEPTH(6), .NCH(4)) dut_b (
    .clk(clk), .rst(rst), .arm(arm), .trig(trig), .trig_mask(trig_mask),
    .trig_edge(trig_edge), .mode(mode), .post_len(post_len),
    .wren(b_wren), .waddr(b_waddr), .rst_trig(b_rst_trig), .busy(b_busy),
    .done(b_done), .trig_addr(b_trig_addr), .trig_ch(b_trig_ch)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int posts;
    int n;
    rst = 1'b1; arm = 1'b0; trig = '0; trig_mask = 4'b0001;
    trig_edge = 1'b0; mode = 1'b0; post_len = 3'd0;

    // Reset and idle behaviour
    repeat (3) tick();
    rst = 1'b0;
    check("rst_wren", a_wren, 0);
    check("rst_waddr", a_waddr, 0);
    check("rst_rst_trig", a_rst_trig, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_trig_addr", a_trig_addr, 0);
    check("rst_trig_ch", a_trig_ch, 0);
    trig = 4'b0001;
    tick();
    trig = '0;
    tick();
    check("idle_trig_wren", a_wren, 0);
    check("idle_trig_busy", a_busy, 0);
    check("idle_trig_done", a_done, 0);

    // Single capture, level mode, post_len=3
    post_len = 3'd3;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("arm_wren", a_wren, 1);
    check("arm_waddr0", a_waddr, 0);
    check("arm_busy", a_busy, 1);
    repeat (4) tick();
    check("armed5_waddr", a_waddr, 4);
    trig = 4'b0001;
    tick();
    trig = '0;
    check("sc_post_waddr5", a_waddr, 5);
    check("sc_post_wren", a_wren, 1);
    check("sc_trig_addr", a_trig_addr, 4);
    check("sc_trig_ch", a_trig_ch, 4'b0001);
    tick();
    check("sc_post_waddr6", a_waddr, 6);
    tick();
    check("sc_post_waddr7", a_waddr, 7);
    tick();
    check("sc_ack_rst_trig", a_rst_trig, 1);
    check("sc_ack_wren", a_wren, 0);
    check("sc_ack_done_not_yet", a_done, 0);
    check("sc_ack_waddr_wrapped", a_waddr, 0);
    tick();
    check("sc_idle_rst_trig", a_rst_trig, 0);
    check("sc_idle_busy", a_busy, 0);
    check("sc_idle_done", a_done, 1);

    // Wrap with DEPTH=6: ten ARMED writes, trigger at address 4, post_len=4
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("wr_done_cleared", b_done, 0);
    for (int i = 0; i < 10; i++) begin
      check("wr_armed_waddr", b_waddr, i % 6);
      tick();
    end
    check("wr_hit_waddr", b_waddr, 4);
    trig = 4'b0001;
    post_len = 3'd4;
    tick();
    trig = '0;
    check("wr_trig_addr", b_trig_addr, 4);
    check("wr_post_waddr5", b_waddr, 5);
    tick();
    check("wr_post_waddr0", b_waddr, 0);
    tick();
    check("wr_post_waddr1", b_waddr, 1);
    tick();
    check("wr_post_waddr2", b_waddr, 2);
    check("wr_post_wren", b_wren, 1);
    tick();
    check("wr_ack_rst_trig", b_rst_trig, 1);
    check("wr_ack_waddr", b_waddr, 3);
    tick();
    check("wr_idle_busy", b_busy, 0);

    // Edge mode: ch1 held high before arm, only the ch2 rise fires; post_len=0
    trig_edge = 1'b1; trig_mask = 4'b0110; trig = 4'b0010; post_len = 3'd0;
    tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    tick();
    check("ed_held_busy", a_busy, 1);
    check("ed_held_wren", a_wren, 1);
    check("ed_held_waddr", a_waddr, 2);
    trig = 4'b0110;
    tick();
    check("ed_pl0_ack", a_rst_trig, 1);
    check("ed_pl0_wren", a_wren, 0);
    check("ed_trig_addr", a_trig_addr, 2);
    check("ed_trig_ch", a_trig_ch, 4'b0100);
    tick();
    check("ed_idle", a_busy, 0);
    trig = '0;
    post_len = 3'd1;
    tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    trig = 4'b0110;
    tick();
    check("ed2_post_wren", a_wren, 1);
    check("ed2_trig_ch", a_trig_ch, 4'b0110);
    check("ed2_trig_addr", a_trig_addr, 1);
    tick();
    check("ed2_ack", a_rst_trig, 1);
    tick();
    check("ed2_idle", a_busy, 0);

    // Clamp on DEPTH=6 (post_len=7 gives 5 post writes) and arm ignored during POST
    trig = '0; trig_edge = 1'b0; trig_mask = 4'b0001;
    tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    trig = 4'b0001;
    post_len = 3'd7;
    tick();
    trig = '0;
    posts = b_wren ? 1 : 0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("arm_in_post_busy", b_busy, 1);
    check("arm_in_post_waddr", b_waddr, 2);
    n = 0;
    while (!b_rst_trig && n < 20) begin
      if (b_wren) posts++;
      tick();
      n++;
    end
    check("cl_ack_reached", b_rst_trig, 1);
    check("cl_post_writes", posts, 5);
    check("cl_trig_addr", b_trig_addr, 0);
    check("cl_ack_waddr", b_waddr, 0);
    n = 0;
    while (a_busy && n < 20) begin
      tick();
      n++;
    end
    check("cl_a_idle", a_busy, 0);
    check("cl_a_done", a_done, 1);
    check("cl_b_done", b_done, 1);

    // Auto-rearm: two captures, one gap cycle each, done stays set
    mode = 1'b1; post_len = 3'd2;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    trig = 4'b0001;
    tick();
    trig = '0;
    tick();
    tick();
    check("ar1_ack", a_rst_trig, 1);
    check("ar1_ack_wren", a_wren, 0);
    check("ar1_ack_waddr", a_waddr, 3);
    tick();
    check("ar1_rearmed_wren", a_wren, 1);
    check("ar1_rearmed_waddr", a_waddr, 3);
    check("ar1_done", a_done, 1);
    check("ar1_rst_trig_low", a_rst_trig, 0);
    trig = 4'b0001;
    tick();
    trig = '0;
    tick();
    tick();
    check("ar2_ack", a_rst_trig, 1);
    check("ar2_ack_waddr", a_waddr, 6);
    check("ar2_done", a_done, 1);
    tick();
    check("ar2_rearmed_wren", a_wren, 1);

    // Reset during POST discards the capture
    trig = 4'b0001;
    tick();
    trig = '0;
    check("rp_in_post", a_wren, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rp_wren", a_wren, 0);
    check("rp_waddr", a_waddr, 0);
    check("rp_rst_trig", a_rst_trig, 0);
    check("rp_busy", a_busy, 0);
    check("rp_done", a_done, 0);
    tick();
    check("rp_no_rst_trig", a_rst_trig, 0);

    // All-zero mask never triggers; only rst exits
    mode = 1'b0; trig_mask = '0; trig = 4'b1111;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (12) tick();
    check("nomask_busy", a_busy, 1);
    check("nomask_no_ack", a_rst_trig, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("nomask_rst_busy", a_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
